// File: rtl/cp0_exc_unit_if.sv
// CP0 bus bundle: mtc0/mfc0 access, interrupt lines, MEM-stage exception
// flags and the exception/EPC/Status/Cause results returned to the pipeline.
interface cp0_exc_unit_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;
    logic [5:0]  int_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic        exc_syscall_i;
    logic        exc_ri_i;
    logic        exc_trap_i;
    logic        exc_ov_i;
    logic        exc_eret_i;
    logic        exc_ucore_i;
    logic [31:0] excepttype_o;
    logic [31:0] epc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, int_i, mem_pc_i, mem_in_delayslot_i,
        output exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, exc_eret_i, exc_ucore_i,
        input  data_o, excepttype_o, epc_o, status_o, cause_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, int_i, mem_pc_i, mem_in_delayslot_i,
        input  exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, exc_eret_i, exc_ucore_i,
        output data_o, excepttype_o, epc_o, status_o, cause_o, timer_int_o
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 register file with MEM-stage exception arbitration and
// commit of exception side-effects (EPC, Status.EXL, Cause.BD/ExcCode).
module cp0_exc_unit #(
    parameter logic [31:0] PRID_VAL   = 32'h004c0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic          clk,
    input  logic          rst,
    cp0_exc_unit_if.slave bus
);
    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_STATUS  = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;
    localparam logic [4:0]  REG_PRID    = 5'd15;
    localparam logic [4:0]  REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_NONE  = 32'h0000_0000;
    localparam logic [31:0] EXC_INT   = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS   = 32'h0000_0008;
    localparam logic [31:0] EXC_RI    = 32'h0000_000a;
    localparam logic [31:0] EXC_OV    = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP  = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET  = 32'h0000_000e;
    localparam logic [31:0] EXC_UCORE = 32'h0000_000f;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic [31:0] status_r;
    logic [31:0] cause_r;
    logic [31:0] epc_r;
    logic        timer_int_r;

    logic        wr_count_s;
    logic        wr_compare_s;
    logic        wr_status_s;
    logic        wr_cause_s;
    logic        wr_epc_s;

    logic [31:0] count_fwd_s;
    logic [31:0] compare_fwd_s;
    logic [31:0] status_fwd_s;
    logic [31:0] cause_fwd_s;
    logic [31:0] epc_fwd_s;

    logic        int_pending_s;
    logic [31:0] excepttype_s;
    logic [31:0] rdata_s;

    logic [31:0] count_nxt_s;
    logic [31:0] compare_nxt_s;
    logic [31:0] status_nxt_s;
    logic [31:0] cause_nxt_s;
    logic [31:0] epc_nxt_s;
    logic        timer_nxt_s;

    // Write decode and same-cycle forwarding of mtc0 data; Cause only takes IP[1:0].
    always_comb begin
        wr_count_s    = bus.we_i && (bus.waddr_i == REG_COUNT);
        wr_compare_s  = bus.we_i && (bus.waddr_i == REG_COMPARE);
        wr_status_s   = bus.we_i && (bus.waddr_i == REG_STATUS);
        wr_cause_s    = bus.we_i && (bus.waddr_i == REG_CAUSE);
        wr_epc_s      = bus.we_i && (bus.waddr_i == REG_EPC);
        count_fwd_s   = wr_count_s   ? bus.wdata_i : count_r;
        compare_fwd_s = wr_compare_s ? bus.wdata_i : compare_r;
        status_fwd_s  = wr_status_s  ? bus.wdata_i : status_r;
        epc_fwd_s     = wr_epc_s     ? bus.wdata_i : epc_r;
        cause_fwd_s   = wr_cause_s   ? {cause_r[31:10], bus.wdata_i[9:8], cause_r[7:0]} : cause_r;
    end

    // Priority arbitration of MEM-stage exceptions; a bubble (pc 0) never raises one.
    always_comb begin
        excepttype_s  = EXC_NONE;
        int_pending_s = ((cause_fwd_s[15:8] & status_fwd_s[15:8]) != 8'h00) &&
                        !status_fwd_s[1] && status_fwd_s[0];
        if (bus.mem_pc_i == 32'h0000_0000) begin
            excepttype_s = EXC_NONE;
        end else if (int_pending_s) begin
            excepttype_s = EXC_INT;
        end else if (bus.exc_syscall_i) begin
            excepttype_s = EXC_SYS;
        end else if (bus.exc_ri_i) begin
            excepttype_s = EXC_RI;
        end else if (bus.exc_trap_i) begin
            excepttype_s = EXC_TRAP;
        end else if (bus.exc_ov_i) begin
            excepttype_s = EXC_OV;
        end else if (bus.exc_eret_i) begin
            excepttype_s = EXC_ERET;
        end else if (bus.exc_ucore_i) begin
            excepttype_s = EXC_UCORE;
        end else begin
            excepttype_s = EXC_NONE;
        end
    end

    // mfc0 read port, showing forwarded values for registers written this cycle.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.raddr_i)
            REG_COUNT:   rdata_s = count_fwd_s;
            REG_COMPARE: rdata_s = compare_fwd_s;
            REG_STATUS:  rdata_s = status_fwd_s;
            REG_CAUSE:   rdata_s = cause_fwd_s;
            REG_EPC:     rdata_s = epc_fwd_s;
            REG_PRID:    rdata_s = PRID_VAL;
            REG_CONFIG:  rdata_s = CONFIG_VAL;
            default:     rdata_s = 32'h0000_0000;
        endcase
    end

    // Next-state: mtc0 values first, then exception/eret fields layered on top.
    always_comb begin
        count_nxt_s   = wr_count_s ? bus.wdata_i : (count_r + 32'd1);
        compare_nxt_s = compare_fwd_s;
        status_nxt_s  = status_fwd_s;
        cause_nxt_s   = {cause_fwd_s[31:16], bus.int_i, cause_fwd_s[9:0]};
        epc_nxt_s     = epc_fwd_s;
        timer_nxt_s   = timer_int_r;
        if (wr_compare_s) begin
            timer_nxt_s = 1'b0;
        end else if ((compare_r != 32'h0000_0000) && (count_r == compare_r)) begin
            timer_nxt_s = 1'b1;
        end else begin
            timer_nxt_s = timer_int_r;
        end
        if (excepttype_s == EXC_ERET) begin
            status_nxt_s[1] = 1'b0;
        end else if (excepttype_s != EXC_NONE) begin
            status_nxt_s[1]  = 1'b1;
            cause_nxt_s[6:2] = excepttype_s[4:0];
            // Nested exception (EXL already set) keeps the original return point.
            if (!status_fwd_s[1]) begin
                epc_nxt_s       = bus.mem_in_delayslot_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;
                cause_nxt_s[31] = bus.mem_in_delayslot_i;
            end else begin
                epc_nxt_s       = epc_fwd_s;
                cause_nxt_s[31] = cause_fwd_s[31];
            end
        end else begin
            status_nxt_s = status_fwd_s;
        end
    end

    // CP0 state registers; reset overrides any pending commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 32'h0000_0000;
            compare_r   <= 32'h0000_0000;
            status_r    <= STATUS_RST;
            cause_r     <= 32'h0000_0000;
            epc_r       <= 32'h0000_0000;
            timer_int_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            compare_r   <= compare_nxt_s;
            status_r    <= status_nxt_s;
            cause_r     <= cause_nxt_s;
            epc_r       <= epc_nxt_s;
            timer_int_r <= timer_nxt_s;
        end
    end

    assign bus.data_o       = rdata_s;
    assign bus.excepttype_o = excepttype_s;
    assign bus.epc_o        = epc_fwd_s;
    assign bus.status_o     = status_fwd_s;
    assign bus.cause_o      = cause_fwd_s;
    assign bus.timer_int_o  = timer_int_r;
endmodule
